// File: rtl/umi_splitter_fifo.sv
// umi_splitter_fifo
//   Buffered UMI traffic splitter. Write traffic (write flag set) is queued
//   towards output 0, all other traffic towards output 1. Each output owns a
//   show-ahead FIFO of DEPTH entries, so a stalled sink only blocks traffic
//   that is headed for it (unless BLOCKING=1, which restores the legacy
//   behaviour of accepting input only when both FIFOs have room).
//
// Ports
//   clk              sole clock, all state updates on its rising edge
//   reset            asynchronous active-high reset of pointers and counts
//   umi_in_valid     input packet valid
//   umi_in_packet    input packet (UW bits)
//   umi_in_ready     input accepted on valid & ready at rising clk
//   umi0_out_*       write-traffic output (valid / packet / ready)
//   umi1_out_*       non-write output (valid / packet / ready)
//   umi0_count       FIFO0 occupancy, 0..DEPTH
//   umi1_count       FIFO1 occupancy, 0..DEPTH
module umi_splitter_fifo #(
  parameter int AW       = 64,
  parameter int UW       = 256,
  parameter int DEPTH    = 4,
  parameter int BLOCKING = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       umi_in_valid,
  input  logic [UW-1:0]              umi_in_packet,
  output logic                       umi_in_ready,
  output logic                       umi0_out_valid,
  output logic [UW-1:0]              umi0_out_packet,
  input  logic                       umi0_out_ready,
  output logic                       umi1_out_valid,
  output logic [UW-1:0]              umi1_out_packet,
  input  logic                       umi1_out_ready,
  output logic [$clog2(DEPTH):0]     umi0_count,
  output logic [$clog2(DEPTH):0]     umi1_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Parameter sanity: the packet must hold the command word plus an
  // address, and the pointer arithmetic relies on DEPTH being a power of two.
  if (UW < 32 + AW) begin : g_bad_uw
    $error("umi_splitter_fifo: UW too small for AW");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("umi_splitter_fifo: DEPTH must be a power of two >= 2");
  end

  // Write flag of the UMI command word, as reported by umi_unpack: bit 0
  // of the command field at the bottom of the packet.
  logic write;
  assign write = umi_in_packet[0];

  logic [1:0]    select_vec;  // bit k set: current packet targets FIFO k
  logic [1:0]    full;
  logic [1:0]    empty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    out_ready;
  logic [UW-1:0] head  [2];
  logic [CW-1:0] count [2];

  assign select_vec = {~write, write};
  assign out_ready  = {umi1_out_ready, umi0_out_ready};

  // Ready looks only at fullness, never at the sink readies, so there is no
  // combinational path from out_ready to in_ready. A full FIFO therefore
  // refuses a push even in a cycle where it pops.
  if (BLOCKING != 0) begin : g_ready_blocking
    assign umi_in_ready = ~full[0] & ~full[1];
  end else begin : g_ready_split
    assign umi_in_ready = write ? ~full[0] : ~full[1];
  end

  assign push = {2{umi_in_valid & umi_in_ready}} & select_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [UW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    assign full[gi]  = (count_reg == FULL_COUNT);
    assign empty[gi] = (count_reg == '0);
    assign pop[gi]   = ~empty[gi] & out_ready[gi];

    // Storage carries no reset; its contents are only observed while the
    // count says the slot is occupied.
    always_ff @(posedge clk) begin
      if (push[gi]) begin
        mem[wr_ptr_reg] <= umi_in_packet;
      end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push[gi]) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop[gi]) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push[gi], pop[gi]})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end

    // Show-ahead head: the oldest entry is presented without a read request,
    // and stays stable until popped.
    assign head[gi]  = mem[rd_ptr_reg];
    assign count[gi] = count_reg;
  end

  assign umi0_out_valid  = ~empty[0];
  assign umi1_out_valid  = ~empty[1];
  assign umi0_out_packet = head[0];
  assign umi1_out_packet = head[1];
  assign umi0_count      = count[0];
  assign umi1_count      = count[1];

endmodule

// File: tb/tb_umi_splitter_fifo.sv
module tb_umi_splitter_fifo;

  localparam int UW    = 256;
  localparam int AW    = 64;
  localparam int DEPTH = 4;

  typedef logic [UW-1:0] pkt_t;

  logic clk;
  logic reset;
  logic in_valid;
  pkt_t in_packet;
  logic r0;
  logic r1;

  // index 0: BLOCKING=0 instance, index 1: BLOCKING=1 instance
  logic       rdy [2];
  logic       v0  [2];
  logic       v1  [2];
  pkt_t       p0  [2];
  pkt_t       p1  [2];
  logic [2:0] c0  [2];
  logic [2:0] c1  [2];

  int n_cmp  = 0;
  int n_fail = 0;

  umi_splitter_fifo #(.AW(AW), .UW(UW), .DEPTH(DEPTH), .BLOCKING(0)) dut_split (
    .clk(clk), .reset(reset),
    .umi_in_valid(in_valid), .umi_in_packet(in_packet), .umi_in_ready(rdy[0]),
    .umi0_out_valid(v0[0]), .umi0_out_packet(p0[0]), .umi0_out_ready(r0),
    .umi1_out_valid(v1[0]), .umi1_out_packet(p1[0]), .umi1_out_ready(r1),
    .umi0_count(c0[0]), .umi1_count(c1[0])
  );

  umi_splitter_fifo #(.AW(AW), .UW(UW), .DEPTH(DEPTH), .BLOCKING(1)) dut_block (
    .clk(clk), .reset(reset),
    .umi_in_valid(in_valid), .umi_in_packet(in_packet), .umi_in_ready(rdy[1]),
    .umi0_out_valid(v0[1]), .umi0_out_packet(p0[1]), .umi0_out_ready(r0),
    .umi1_out_valid(v1[1]), .umi1_out_packet(p1[1]), .umi1_out_ready(r1),
    .umi0_count(c0[1]), .umi1_count(c1[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: one queue per output ----------------
  // q[2*i + k] is output k of instance i.
  pkt_t q [4][$];

  function automatic logic m_ready(int i, pkt_t p);
    if (i == 1) return (q[2].size() < DEPTH) && (q[3].size() < DEPTH);
    return p[0] ? (q[0].size() < DEPTH) : (q[1].size() < DEPTH);
  endfunction

  always @(posedge clk or posedge reset) begin
    logic acc;
    int   dst;
    if (reset) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        acc = in_valid && m_ready(i, in_packet);
        dst = 2 * i + (in_packet[0] ? 0 : 1);
        if (q[2*i].size() > 0 && r0) begin
          if (i == 0) $display("[%0t] pop  out0 data=%08h", $time, q[0][0][255:224]);
          void'(q[2*i].pop_front());
        end
        if (q[2*i+1].size() > 0 && r1) begin
          if (i == 0) $display("[%0t] pop  out1 data=%08h", $time, q[1][0][255:224]);
          void'(q[2*i+1].pop_front());
        end
        if (acc) begin
          if (i == 0) $display("[%0t] push out%0d data=%08h", $time, dst, in_packet[255:224]);
          q[dst].push_back(in_packet);
        end
      end
    end
  end

  task automatic check(input string nm, input pkt_t act, input pkt_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ready[%0d]", i), pkt_t'(rdy[i]), pkt_t'(m_ready(i, in_packet)));
        check($sformatf("valid0[%0d]", i), pkt_t'(v0[i]), pkt_t'(q[2*i].size() > 0));
        check($sformatf("valid1[%0d]", i), pkt_t'(v1[i]), pkt_t'(q[2*i+1].size() > 0));
        check($sformatf("count0[%0d]", i), pkt_t'(c0[i]), pkt_t'(q[2*i].size()));
        check($sformatf("count1[%0d]", i), pkt_t'(c1[i]), pkt_t'(q[2*i+1].size()));
        if (q[2*i].size() > 0)
          check($sformatf("packet0[%0d]", i), p0[i], q[2*i][0]);
        if (q[2*i+1].size() > 0)
          check($sformatf("packet1[%0d]", i), p1[i], q[2*i+1][0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic pkt_t wr(input logic [31:0] d);
    pkt_t p;
    p = '0;
    p[255:224] = d;
    p[0] = 1'b1;
    return p;
  endfunction

  function automatic pkt_t rd(input logic [31:0] d);
    pkt_t p;
    p = '0;
    p[255:224] = d;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] abc [3];
    logic        accepted;
    int          budget;
    abc[0] = 32'hA;
    abc[1] = 32'hB;
    abc[2] = 32'hC;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_packet = '0;
    r0        = 1'b1;
    r1        = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", pkt_t'(rdy[i]), pkt_t'(1'b1));
      check("rst_valid0", pkt_t'(v0[i]), pkt_t'(1'b0));
      check("rst_count1", pkt_t'(c1[i]), pkt_t'(3'd0));
    end

    // Three writes with both sinks ready: one-cycle latency, back to back.
    in_valid  = 1'b1;
    in_packet = wr(abc[0]);
    #1 check("no_bypass", pkt_t'(v0[0]), pkt_t'(1'b0));
    for (int j = 0; j < 3; j++) begin
      in_packet = wr(abc[j]);
      step();
      check("abc_valid", pkt_t'(v0[0]), pkt_t'(1'b1));
      check("abc_packet", p0[0], wr(abc[j]));
    end
    in_valid = 1'b0;
    step();
    check("abc_drained", pkt_t'(v0[0]), pkt_t'(1'b0));

    // Fill FIFO0 with its sink stalled.
    r0 = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_packet = wr(32'h10 + j);
      step();
    end
    in_packet = wr(32'h20);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("full_count", pkt_t'(c0[i]), pkt_t'(3'd4));
      check("full_ready", pkt_t'(rdy[i]), pkt_t'(1'b0));
    end
    step();
    in_packet = rd(32'h30);
    #1;
    check("read_ready_split", pkt_t'(rdy[0]), pkt_t'(1'b1));
    check("read_ready_block", pkt_t'(rdy[1]), pkt_t'(1'b0));
    step();
    check("read_out_split", p1[0], rd(32'h30));
    check("read_none_block", pkt_t'(v1[1]), pkt_t'(1'b0));
    r0 = 1'b1;
    step();
    r0 = 1'b0;
    check("block_pop_count", pkt_t'(c0[1]), pkt_t'(3'd3));
    check("block_ready_up", pkt_t'(rdy[1]), pkt_t'(1'b1));
    step();
    check("block_read_out", p1[1], rd(32'h30));

    // Refill, then a single pop with a write pending.
    in_packet = wr(32'h21);
    step();
    in_packet = wr(32'h22);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("pend_count4", pkt_t'(c0[i]), pkt_t'(3'd4));
      check("pend_ready0", pkt_t'(rdy[i]), pkt_t'(1'b0));
    end
    r0 = 1'b1;
    step();
    r0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("pend_count3", pkt_t'(c0[i]), pkt_t'(3'd3));
      check("pend_ready1", pkt_t'(rdy[i]), pkt_t'(1'b1));
    end
    step();
    for (int i = 0; i < 2; i++)
      check("pend_count_back", pkt_t'(c0[i]), pkt_t'(3'd4));
    in_valid = 1'b0;
    r0 = 1'b1;
    repeat (8) step();

    // Ten writes with a random sink: order across pointer wrap.
    for (int j = 0; j < 10; j++) begin
      in_packet = wr(32'h40 + j);
      in_valid  = 1'b1;
      budget    = 0;
      do begin
        r0 = 1'($urandom_range(1, 0));
        #1;
        accepted = m_ready(0, in_packet);
        step();
        budget++;
      end while (!accepted && budget < 100);
      if (!accepted) begin
        n_fail++;
        $display("FAIL stream_timeout: write %0d not accepted within %0d cycles, required acceptance", j, budget);
      end
    end
    in_valid = 1'b0;
    r0 = 1'b1;
    repeat (8) step();

    // Two entries in each FIFO, then reset mid-operation.
    r0 = 1'b0;
    r1 = 1'b0;
    in_valid = 1'b1;
    in_packet = wr(32'h50); step();
    in_packet = wr(32'h51); step();
    in_packet = rd(32'h52); step();
    in_packet = rd(32'h53); step();
    in_valid = 1'b0;
    check("pre_rst_count0", pkt_t'(c0[0]), pkt_t'(3'd2));
    check("pre_rst_count1", pkt_t'(c1[0]), pkt_t'(3'd2));
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("arst_valid0", pkt_t'(v0[i]), pkt_t'(1'b0));
      check("arst_valid1", pkt_t'(v1[i]), pkt_t'(1'b0));
      check("arst_count0", pkt_t'(c0[i]), pkt_t'(3'd0));
      check("arst_count1", pkt_t'(c1[i]), pkt_t'(3'd0));
    end
    @(posedge clk);
    #1 reset = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    in_packet = wr(32'h60);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", pkt_t'(v0[0]), pkt_t'(1'b1));
    check("post_rst_packet", p0[0], wr(32'h60));
    check("post_rst_no_stale", pkt_t'(v1[0]), pkt_t'(1'b0));
    step();
    check("post_rst_drained", pkt_t'(v0[0]), pkt_t'(1'b0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/umi_splitter_fifo.md
# umi_splitter_fifo

Buffered, non-blocking UMI traffic splitter. Decodes each input packet's write flag: write traffic goes to output 0 (high priority), everything else goes to output 1 (low priority). Each output has its own FIFO of parametrised depth, so a stalled output does not block traffic bound for the other. It sits between a UMI source and two independently back-pressured UMI sinks, and replaces the combinational, globally-blocking splitter where decoupling is needed.

## Interface
Parameters:
- AW, 64, UMI address width passed to umi_unpack
- UW, 256, UMI packet width
- DEPTH, 4, entries per output FIFO; power of two, ≥2
- BLOCKING, 0, 1 = legacy mode: input ready only when both FIFOs have space

Ports:
- clk  input  1  sole clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- umi_in_valid  input  1  input packet valid
- umi_in_packet  input  UW  input packet
- umi_in_ready  output  1  input accepted when valid&ready at rising clk
- umi0_out_valid  output  1  write-traffic output valid
- umi0_out_packet  output  UW  write-traffic packet
- umi0_out_ready  input  1  write-traffic sink ready
- umi1_out_valid  output  1  non-write output valid
- umi1_out_packet  output  UW  non-write packet
- umi1_out_ready  input  1  non-write sink ready
- umi0_count  output  $clog2(DEPTH)+1  FIFO0 occupancy
- umi1_count  output  $clog2(DEPTH)+1  FIFO1 occupancy

## Operation
- Decode: `write` is taken from umi_unpack on umi_in_packet. write=1 selects FIFO0; write=0 selects FIFO1.
- Each FIFO has storage of DEPTH×UW, read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register of $clog2(DEPTH)+1 bits.
- full_k = (count_k == DEPTH). empty_k = (count_k == 0).
- umi_in_ready:
  - BLOCKING=0: ~full of the FIFO selected by the current packet's write bit. It is decoded combinationally from umi_in_packet, independent of umi_in_valid.
  - BLOCKING=1: ~full0 & ~full1.
- Push to FIFO k when umi_in_valid & umi_in_ready & (selection == k). The packet is stored unmodified and broadcast to no other output.
- umiK_out_valid = ~empty_k. umiK_out_packet = storage at read pointer of FIFO k.
- Pop FIFO k when umiK_out_valid & umiK_out_ready.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance.
- Per-output order is preserved. Relative order between outputs is not preserved.
- Ready never depends on umiK_out_ready, so there is no combinational path from out_ready to in_ready. A full FIFO does not accept a push in the same cycle it pops.
- Storage is not reset. umiK_out_packet is don't-care while umiK_out_valid=0.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - pointers = 0, counts = 0
  - umi0/1_out_valid = 0, umi0/1_count = 0
  - umi_in_ready = 1 in both modes
- Latency: a packet accepted at edge N shows valid on its output after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: one packet per cycle into either FIFO while it is not full. Each output sustains one pop per cycle.
- Boundary conditions:
  - Full: ready drops for packets targeting that FIFO. A packet targeting the other, non-full FIFO is still accepted when BLOCKING=0.
  - Empty with simultaneous push: the pop is impossible (valid=0), so count becomes 1.
  - Full with pop: the count falls to DEPTH−1 and ready rises the next cycle.
  - Wrap-around: pointer DEPTH−1 increments to 0 with no bubble.
  - Reset mid-operation: all queued packets are discarded, and outputs go invalid immediately on reset assertion.
- The UMI valid/ready rule holds on outputs: once valid is high, it and the packet stay stable until popped (FIFO head is stable).

## Test plan
- Reset, then with DEPTH=4 send 3 writes (data A,B,C) with both readies high → umi0 outputs A,B,C on consecutive cycles, first valid 1 cycle after acceptance. umi1_out_valid stays 0.
- Hold umi0_out_ready=0 and push 4 writes → umi0_count=4 and ready=0 for a 5th write. A read packet is still accepted and appears on umi1 (BLOCKING=0).
- Same stimulus with BLOCKING=1 → after FIFO0 fills, ready=0 for the read packet too; no umi1 traffic until one umi0 pop.
- Full FIFO0: assert umi0_out_ready for 1 cycle with a write pending → count goes 4→3; the pending write is accepted on the following edge; count returns to 4.
- Stream 10 writes with random umi0_out_ready → output order matches input order across pointer wrap; count never exceeds 4.
- Assert reset while both FIFOs hold 2 entries → valids and counts go 0 asynchronously. After release, the first new packet has 1-cycle latency and no stale data appears.
